// File: rtl/fc_sequencer_if.sv
// Datapath link between the sequencer and fc_module: phase command/size out, done pulses and result in.
// Pure wiring, no latency of its own.
// No backpressure; the datapath acknowledges each phase with a one-cycle done pulse.
interface fc_sequencer_if #(
   parameter int SIZE_W = 21
);
   logic [2:0]        receiveCommand;
   logic [SIZE_W-1:0] receive_size;
   logic              feature_receive_done;
   logic              bias_receive_done;
   logic              weight_receive_done;
   logic              fc_done;
   logic [31:0]       max_index;

   // Sequencer side: issues commands, consumes done pulses and the result.
   modport master (
      output receiveCommand,
      output receive_size,
      input  feature_receive_done,
      input  bias_receive_done,
      input  weight_receive_done,
      input  fc_done,
      input  max_index
   );

   // Datapath side: consumes commands, produces done pulses and the result.
   modport slave (
      input  receiveCommand,
      input  receive_size,
      output feature_receive_done,
      output bias_receive_done,
      output weight_receive_done,
      output fc_done,
      output max_index
   );
endinterface

// File: rtl/fc_sequencer.sv
// Runs one FC inference (feature, bias, N weight chunks, compute) against fc_module with per-phase watchdog.
// All outputs registered: start -> first command next cycle; done pulse -> 1-cycle GAP -> next command.
// No backpressure: phases advance only on matching done pulses; start while busy is dropped.
module fc_sequencer #(
   parameter int SIZE_W    = 21,
   parameter int CHUNK_W   = 8,
   parameter int TIMEOUT_W = 20
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 start,
   input  logic                 abort,
   input  logic [SIZE_W-1:0]    feat_size,
   input  logic [SIZE_W-1:0]    bias_size,
   input  logic [SIZE_W-1:0]    weight_size,
   input  logic [CHUNK_W-1:0]   weight_chunks,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   fc_sequencer_if.master       dp,
   output logic                 busy,
   output logic                 seq_done,
   output logic                 error,
   output logic [2:0]           err_phase,
   output logic [31:0]          result_index,
   output logic [31:0]          cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FEAT = 3'd1,
      S_BIAS = 3'd2,
      S_WGT  = 3'd3,
      S_COMP = 3'd4,
      S_GAP  = 3'd5,
      S_FIN  = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   state_t               state_q, state_d;
   state_t               last_q, last_d;      // phase that just finished, consulted in GAP
   logic [SIZE_W-1:0]    feat_sz_q, feat_sz_d;
   logic [SIZE_W-1:0]    bias_sz_q, bias_sz_d;
   logic [SIZE_W-1:0]    wgt_sz_q, wgt_sz_d;
   logic [CHUNK_W-1:0]   chunks_q, chunks_d;
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic [CHUNK_W-1:0]   chunk_cnt_q, chunk_cnt_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [2:0]           cmd_q, cmd_d;
   logic [SIZE_W-1:0]    size_q, size_d;
   logic                 busy_q, busy_d;
   logic                 seq_done_q, seq_done_d;
   logic                 error_q, error_d;
   logic [2:0]           err_phase_q, err_phase_d;
   logic [31:0]          result_q, result_d;
   logic [31:0]          cyc_q, cyc_d;

   logic                 in_phase;
   logic                 phase_done;
   logic                 wd_expire;
   logic                 go_err;

   // Picks the next phase after 'from', skipping empty phases; COMP is the fallback and never skipped.
   function automatic state_t next_phase(input state_t from, input logic f_nz,
                                         input logic b_nz, input logic w_more);
      state_t nxt;
      nxt = S_COMP;
      if (w_more)
         nxt = S_WGT;
      if (b_nz && (from == S_IDLE || from == S_FEAT))
         nxt = S_BIAS;
      if (f_nz && from == S_IDLE)
         nxt = S_FEAT;
      return nxt;
   endfunction

   // Next-state, shadow config, counters and registered output values.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      feat_sz_d   = feat_sz_q;
      bias_sz_d   = bias_sz_q;
      wgt_sz_d    = wgt_sz_q;
      chunks_d    = chunks_q;
      limit_d     = limit_q;
      chunk_cnt_d = chunk_cnt_q;
      error_d     = error_q;
      err_phase_d = err_phase_q;
      result_d    = result_q;
      cyc_d       = cyc_q;
      go_err      = 1'b0;
      cmd_d       = 3'd0;
      size_d      = '0;
      busy_d      = 1'b0;
      seq_done_d  = 1'b0;

      in_phase   = (state_q == S_FEAT) || (state_q == S_BIAS) ||
                   (state_q == S_WGT)  || (state_q == S_COMP);
      phase_done = ((state_q == S_FEAT) && dp.feature_receive_done) ||
                   ((state_q == S_BIAS) && dp.bias_receive_done)    ||
                   ((state_q == S_WGT)  && dp.weight_receive_done)  ||
                   ((state_q == S_COMP) && dp.fc_done);
      wd_expire  = (limit_q != '0) && (wd_q == limit_q);

      // Run-time counter covers every busy cycle through FIN and saturates.
      if (state_q != S_IDLE && state_q != S_ERR && cyc_q != '1)
         cyc_d = cyc_q + 32'd1;

      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               feat_sz_d   = feat_size;
               bias_sz_d   = bias_size;
               wgt_sz_d    = weight_size;
               chunks_d    = weight_chunks;
               limit_d     = timeout_limit;
               chunk_cnt_d = '0;
               cyc_d       = '0;
               error_d     = 1'b0;
               err_phase_d = 3'd0;
               state_d     = next_phase(S_IDLE, feat_size != '0, bias_size != '0,
                                        (weight_size != '0) && (weight_chunks != '0));
            end
         end
         S_FEAT, S_BIAS, S_WGT, S_COMP: begin
            // Abort beats a done pulse; a done pulse beats watchdog expiry.
            if (abort) begin
               go_err = 1'b1;
            end else if (phase_done) begin
               if (state_q == S_COMP) begin
                  result_d = dp.max_index;
                  state_d  = S_FIN;
               end else begin
                  if (state_q == S_WGT)
                     chunk_cnt_d = chunk_cnt_q + 1'b1;
                  last_d  = state_q;
                  state_d = S_GAP;
               end
            end else if (wd_expire) begin
               go_err = 1'b1;
            end
         end
         S_GAP: begin
            if (abort)
               go_err = 1'b1;
            else
               state_d = next_phase(last_q, feat_sz_q != '0, bias_sz_q != '0,
                                    (wgt_sz_q != '0) && (chunk_cnt_q < chunks_q));
         end
         S_FIN: begin
            if (abort)
               go_err = 1'b1;
            else
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (go_err) begin
         state_d     = S_ERR;
         error_d     = 1'b1;
         err_phase_d = cmd_q;
      end

      // Watchdog restarts on every state change, so each phase entry sees zero.
      wd_d = (in_phase && state_d == state_q) ? wd_q + 1'b1 : '0;

      // Outputs are decoded from the upcoming state so they line up with it.
      case (state_d)
         S_FEAT: begin cmd_d = 3'd1; size_d = feat_sz_d; end
         S_BIAS: begin cmd_d = 3'd2; size_d = bias_sz_d; end
         S_WGT:  begin cmd_d = 3'd3; size_d = wgt_sz_d;  end
         S_COMP: begin cmd_d = 3'd4; size_d = '0;        end
         default: begin cmd_d = 3'd0; size_d = '0;       end
      endcase
      busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
      seq_done_d = (state_d == S_FIN);
   end

   // State, shadow and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         last_q      <= S_IDLE;
         feat_sz_q   <= '0;
         bias_sz_q   <= '0;
         wgt_sz_q    <= '0;
         chunks_q    <= '0;
         limit_q     <= '0;
         chunk_cnt_q <= '0;
         wd_q        <= '0;
         cmd_q       <= 3'd0;
         size_q      <= '0;
         busy_q      <= 1'b0;
         seq_done_q  <= 1'b0;
         error_q     <= 1'b0;
         err_phase_q <= 3'd0;
         result_q    <= '0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         feat_sz_q   <= feat_sz_d;
         bias_sz_q   <= bias_sz_d;
         wgt_sz_q    <= wgt_sz_d;
         chunks_q    <= chunks_d;
         limit_q     <= limit_d;
         chunk_cnt_q <= chunk_cnt_d;
         wd_q        <= wd_d;
         cmd_q       <= cmd_d;
         size_q      <= size_d;
         busy_q      <= busy_d;
         seq_done_q  <= seq_done_d;
         error_q     <= error_d;
         err_phase_q <= err_phase_d;
         result_q    <= result_d;
         cyc_q       <= cyc_d;
      end
   end

   assign dp.receiveCommand = cmd_q;
   assign dp.receive_size   = size_q;
   assign busy              = busy_q;
   assign seq_done          = seq_done_q;
   assign error             = error_q;
   assign err_phase         = err_phase_q;
   assign result_index      = result_q;
   assign cycle_count       = cyc_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: full run, chunking, skips, watchdog, hazards, mid-run reset.
// Inputs change and outputs are sampled on the falling edge.
// Datapath done pulses are issued 5 cycles after each command appears.
module tb_fc_sequencer;
   logic        CLK = 1'b0;
   logic        RESET, start, abort;
   logic [20:0] feat_size, bias_size, weight_size;
   logic [7:0]  weight_chunks;
   logic [19:0] timeout_limit;
   logic        busy, seq_done, error;
   logic [2:0]  err_phase;
   logic [31:0] result_index, cycle_count;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   fc_sequencer_if #(.SIZE_W(21)) dp ();

   fc_sequencer dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .start         (start),
      .abort         (abort),
      .feat_size     (feat_size),
      .bias_size     (bias_size),
      .weight_size   (weight_size),
      .weight_chunks (weight_chunks),
      .timeout_limit (timeout_limit),
      .dp            (dp),
      .busy          (busy),
      .seq_done      (seq_done),
      .error         (error),
      .err_phase     (err_phase),
      .result_index  (result_index),
      .cycle_count   (cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic cfg(input int f, input int b, input int w, input int c, input int l);
      feat_size     = 21'(f);
      bias_size     = 21'(b);
      weight_size   = 21'(w);
      weight_chunks = 8'(c);
      timeout_limit = 20'(l);
   endtask

   task automatic check_reset_vals(input string tag);
      chk($sformatf("%s.cmd", tag),   32'(dp.receiveCommand), 0);
      chk($sformatf("%s.size", tag),  32'(dp.receive_size),   0);
      chk($sformatf("%s.busy", tag),  32'(busy),              0);
      chk($sformatf("%s.done", tag),  32'(seq_done),          0);
      chk($sformatf("%s.err", tag),   32'(error),             0);
      chk($sformatf("%s.ephase", tag),32'(err_phase),         0);
      chk($sformatf("%s.res", tag),   result_index,           0);
      chk($sformatf("%s.cyc", tag),   cycle_count,            0);
   endtask

   // Called at a falling edge; returns at the falling edge where the first command should show.
   task automatic do_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Entered at the first cycle of a phase; returns at the first cycle after its GAP (or FIN).
   // hz[0]: stray weight done mid-phase, hz[1]: start mid-phase.
   task automatic phase(input string tag, input int ecmd, input int esz, input logic [1:0] hz,
                        input int eres);
      chk($sformatf("%s.cmd", tag),  32'(dp.receiveCommand), 32'(ecmd));
      chk($sformatf("%s.size", tag), 32'(dp.receive_size),   32'(esz));
      chk($sformatf("%s.busy", tag), 32'(busy),              1);
      repeat (2) @(negedge CLK);
      if (hz[0]) dp.weight_receive_done = 1'b1;
      if (hz[1]) start = 1'b1;
      @(negedge CLK);
      dp.weight_receive_done = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge CLK);
      chk($sformatf("%s.hold", tag), 32'(dp.receiveCommand), 32'(ecmd));
      case (ecmd)
         1: dp.feature_receive_done = 1'b1;
         2: dp.bias_receive_done    = 1'b1;
         3: dp.weight_receive_done  = 1'b1;
         default: dp.fc_done        = 1'b1;
      endcase
      @(negedge CLK);
      dp.feature_receive_done = 1'b0;
      dp.bias_receive_done    = 1'b0;
      dp.weight_receive_done  = 1'b0;
      dp.fc_done              = 1'b0;
      if (ecmd == 4) begin
         chk($sformatf("%s.seqdone", tag), 32'(seq_done), 1);
         chk($sformatf("%s.result", tag),  result_index,  32'(eres));
      end else begin
         chk($sformatf("%s.gapcmd", tag),  32'(dp.receiveCommand), 0);
         chk($sformatf("%s.gapbusy", tag), 32'(busy),              1);
      end
      @(negedge CLK);
   endtask

   task automatic check_idle(input string tag, input int ecyc);
      chk($sformatf("%s.seqdone", tag), 32'(seq_done), 0);
      chk($sformatf("%s.busy", tag),    32'(busy),     0);
      chk($sformatf("%s.cyc", tag),     cycle_count,   32'(ecyc));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish required finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      RESET = 1'b1; start = 1'b0; abort = 1'b0;
      cfg(0, 0, 0, 0, 0);
      dp.feature_receive_done = 1'b0;
      dp.bias_receive_done    = 1'b0;
      dp.weight_receive_done  = 1'b0;
      dp.fc_done              = 1'b0;
      dp.max_index            = 32'd0;
      repeat (3) @(negedge CLK);
      check_reset_vals("rst");
      RESET = 1'b0;
      @(negedge CLK);

      // abort in IDLE does nothing
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      @(negedge CLK);
      chk("idle_abort.err",  32'(error), 0);
      chk("idle_abort.busy", 32'(busy),  0);

      // full run; config scrambled after acceptance must not matter
      cfg(784, 10, 7840, 1, 0);
      dp.max_index = 32'd7;
      do_start();
      chk("full.err", 32'(error), 0);
      cfg(1, 0, 0, 0, 1);
      phase("full.f", 1, 784, 2'b00, 0);
      phase("full.b", 2, 10, 2'b00, 0);
      phase("full.w", 3, 7840, 2'b00, 0);
      phase("full.c", 4, 0, 2'b00, 7);
      check_idle("full.end", 28);

      // three weight chunks
      cfg(4, 4, 100, 3, 0);
      dp.max_index = 32'd3;
      do_start();
      phase("chk.f", 1, 4, 2'b00, 0);
      phase("chk.b", 2, 4, 2'b00, 0);
      phase("chk.w1", 3, 100, 2'b00, 0);
      phase("chk.w2", 3, 100, 2'b00, 0);
      phase("chk.w3", 3, 100, 2'b00, 0);
      phase("chk.c", 4, 0, 2'b00, 3);
      check_idle("chk.end", 42);

      // all loads skipped
      cfg(0, 0, 0, 1, 0);
      dp.max_index = 32'd5;
      do_start();
      phase("skip.c", 4, 0, 2'b00, 5);
      check_idle("skip.end", 7);

      // zero chunks skips WGT even with a weight size
      cfg(0, 6, 9, 0, 0);
      do_start();
      phase("skip2.b", 2, 6, 2'b00, 0);
      phase("skip2.c", 4, 0, 2'b00, 5);
      check_idle("skip2.end", 14);

      // watchdog on BIAS, done withheld
      cfg(0, 8, 0, 0, 16);
      do_start();
      chk("wd.cmd", 32'(dp.receiveCommand), 2);
      repeat (16) @(negedge CLK);
      chk("wd.pre_cmd", 32'(dp.receiveCommand), 2);
      chk("wd.pre_err", 32'(error), 0);
      @(negedge CLK);
      chk("wd.cmd0",   32'(dp.receiveCommand), 0);
      chk("wd.err",    32'(error),     1);
      chk("wd.ephase", 32'(err_phase), 2);
      chk("wd.busy",   32'(busy),      0);
      chk("wd.cyc",    cycle_count,    17);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      repeat (2) @(negedge CLK);
      chk("wd.hold_err", 32'(error), 1);
      chk("wd.hold_cyc", cycle_count, 17);

      // restart from ERR; limit 5 expires on the same cycle as each done pulse
      cfg(0, 8, 0, 0, 5);
      dp.max_index = 32'd11;
      do_start();
      chk("wd2.err",    32'(error),     0);
      chk("wd2.ephase", 32'(err_phase), 0);
      phase("wd2.b", 2, 8, 2'b00, 0);
      phase("wd2.c", 4, 0, 2'b00, 11);
      chk("wd2.err_end", 32'(error), 0);
      check_idle("wd2.end", 14);

      // hazards: stray weight done in FEAT, start in BIAS, abort with fc_done in COMP
      cfg(3, 3, 3, 2, 0);
      dp.max_index = 32'd9;
      do_start();
      phase("hz.f", 1, 3, 2'b01, 0);
      phase("hz.b", 2, 3, 2'b10, 0);
      phase("hz.w1", 3, 3, 2'b00, 0);
      phase("hz.w2", 3, 3, 2'b00, 0);
      chk("hz.comp", 32'(dp.receiveCommand), 4);
      repeat (2) @(negedge CLK);
      abort = 1'b1;
      dp.fc_done = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      dp.fc_done = 1'b0;
      chk("hz.cmd0",   32'(dp.receiveCommand), 0);
      chk("hz.err",    32'(error),     1);
      chk("hz.ephase", 32'(err_phase), 4);
      chk("hz.busy",   32'(busy),      0);
      chk("hz.seqd",   32'(seq_done),  0);
      chk("hz.res",    result_index,   11);

      // reset during the second weight chunk
      cfg(2, 2, 50, 3, 0);
      dp.max_index = 32'd21;
      do_start();
      phase("rs.f", 1, 2, 2'b00, 0);
      phase("rs.b", 2, 2, 2'b00, 0);
      phase("rs.w1", 3, 50, 2'b00, 0);
      chk("rs.w2", 32'(dp.receiveCommand), 3);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check_reset_vals("rs.mid");
      RESET = 1'b0;
      do_start();
      phase("rs2.f", 1, 2, 2'b00, 0);
      phase("rs2.b", 2, 2, 2'b00, 0);
      phase("rs2.w1", 3, 50, 2'b00, 0);
      phase("rs2.w2", 3, 50, 2'b00, 0);
      phase("rs2.w3", 3, 50, 2'b00, 0);
      phase("rs2.c", 4, 0, 2'b00, 21);
      check_idle("rs2.end", 42);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fc_sequencer.md
# fc_sequencer

Hardware sequencer for the fully-connected accelerator. It replaces the per-phase APB writes software currently issues, and drives `receiveCommand`/`receive_size` through one complete inference: feature load, bias load, N weight chunks, then compute. Each phase waits on the matching done pulse from the FC datapath, a per-phase watchdog guards every wait, and the block captures `max_index` and total cycle count at completion. It sits between the APB register block (which provides the configuration and `start`) and `fc_module`.

## Interface
- `SIZE_W`, 21, width of every size field and of `receive_size`
- `CHUNK_W`, 8, width of the weight chunk count
- `TIMEOUT_W`, 20, width of the watchdog limit and watchdog counter

- `CLK` in 1: single clock, rising edge
- `RESET` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request to run a sequence
- `abort` in 1: level, forces ERR from any busy state
- `feat_size` in SIZE_W: feature words to receive
- `bias_size` in SIZE_W: bias words to receive
- `weight_size` in SIZE_W: weight words per chunk
- `weight_chunks` in CHUNK_W: number of weight chunks
- `timeout_limit` in TIMEOUT_W: cycles allowed per phase; 0 disables the watchdog
- `feature_receive_done`, `bias_receive_done`, `weight_receive_done`, `fc_done` in 1 each: one-cycle done pulses from the datapath
- `max_index` in 32: result from the datapath
- `receiveCommand` out 3: 0 idle, 1 feature, 2 bias, 3 weight, 4 compute
- `receive_size` out SIZE_W: word count for the active phase
- `busy` out 1: high in every state except IDLE and ERR
- `seq_done` out 1: one-cycle completion pulse
- `error` out 1: sticky error flag
- `err_phase` out 3: `receiveCommand` value active when the error occurred
- `result_index` out 32: `max_index` captured at `fc_done`
- `cycle_count` out 32: cycles from start acceptance to `seq_done`, saturating

## Operation
- States: IDLE, FEAT, BIAS, WGT, COMP, GAP, FIN, ERR. All outputs are registered.
- IDLE:
  - A `start` pulse latches all config inputs into shadow registers, clears `cycle_count`, `error` and `err_phase`, and moves to the first non-skipped phase.
  - Config changes after acceptance have no effect on the running sequence.
- Phase order: FEAT → BIAS → WGT (repeated `weight_chunks` times) → COMP.
  - FEAT is skipped if `feat_size`=0.
  - BIAS is skipped if `bias_size`=0.
  - WGT is skipped if `weight_size`=0 or `weight_chunks`=0.
  - COMP is never skipped.
- In a phase state, `receiveCommand` holds the phase code and `receive_size` holds the latched size (0 in COMP). Both stay stable for the whole phase.
- The matching done pulse moves the FSM to GAP.
  - GAP drives `receiveCommand`=0 and `receive_size`=0 for exactly 1 cycle, then enters the next phase.
  - In WGT, the chunk counter increments on each `weight_receive_done`. GAP returns to WGT until the count equals `weight_chunks`.
- Done pulses that do not match the current phase are ignored, including pulses seen in IDLE or GAP.
- COMP + `fc_done`: capture `max_index` into `result_index` and go to FIN.
  - FIN asserts `seq_done` for 1 cycle, then returns to IDLE. `result_index` holds until the next `fc_done` capture.
- Watchdog:
  - The counter clears on every phase entry and increments each cycle in a phase state.
  - If `timeout_limit`≠0 and the counter reaches `timeout_limit` without the matching done pulse, go to ERR.
- ERR:
  - Entered on watchdog expiry, or on `abort` while busy.
  - Sets `error`=1 and `err_phase`=current command (0 if entered from GAP). Drives `receiveCommand`=0, `receive_size`=0, `busy`=0.
  - Leaves only on `start`, which clears `error` and begins a new sequence, or on `RESET`.
- `abort` in IDLE or ERR has no effect.
- `start` while busy is ignored.
- `cycle_count`:
  - Increments every cycle from the cycle after start acceptance through the FIN cycle.
  - Saturates at 0xFFFFFFFF.
  - Holds its value in IDLE and ERR.

## Timing
- Reset values: state IDLE; `receiveCommand`=0, `receive_size`=0, `busy`=0, `seq_done`=0, `error`=0, `err_phase`=0, `result_index`=0, `cycle_count`=0.
- `start` sampled at cycle t → first phase command visible at t+1, with `busy`=1 at t+1.
- Done pulse at cycle t → GAP at t+1 → next command at t+2.
- `fc_done` at t → `result_index` valid and `seq_done`=1 at t+1 → IDLE at t+2.
- Watchdog: phase entered at t, no done pulse → ERR outputs at t+`timeout_limit`+1.
- If the done pulse and watchdog expiry occur in the same cycle, the done pulse wins.
- If `abort` and a done pulse occur in the same cycle, abort wins.
- `RESET` mid-sequence returns every output to its reset value on the next edge, regardless of state.

## Test plan
- Full run:
  - Stimulus: feat 784, bias 10, weight 7840, chunks 1, limit 0. Respond to each command with its done pulse 5 cycles after the command appears.
  - Required: command sequence 1,0,2,0,3,0,4. `max_index`=7 at `fc_done` gives `result_index`=7 and a single `seq_done` pulse. `cycle_count` matches the computed total.
- Chunked weights:
  - Stimulus: chunks 3, weight 100.
  - Required: exactly three WGT phases, each with `receive_size`=100 and separated by 1-cycle GAPs, before command 4.
- Skips:
  - Stimulus: feat 0, bias 0, weight 0, then `start`.
  - Required: `receiveCommand`=4 at t+1. `fc_done` leads to `seq_done`.
- Watchdog:
  - Stimulus: limit 16, `bias_receive_done` withheld.
  - Required: ERR 17 cycles after BIAS entry, with `error`=1, `err_phase`=2, `receiveCommand`=0. A following `start` clears `error` and runs normally.
- Hazards:
  - Stimulus: stray `weight_receive_done` during FEAT, `start` during BIAS, `abort` during COMP.
  - Required: the stray pulse and the mid-run `start` are ignored. `abort` gives ERR with `err_phase`=4.
- Reset: `RESET` asserted during WGT chunk 2 → all outputs at reset values next cycle; the next `start` restarts from FEAT.
